// File: rtl/spi_sram_multi.sv
// spi_sram_multi: bridges a word-addressed bus slave onto N_CS serial SPI SRAMs
// (READ 0x03 / WRITE 0x02, sequential mode). Writes only send the byte span
// from the lowest to the highest enabled byte lane.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for cyc; request latched on acceptance
// S_SETUP | CS asserted, first MOSI bit held for CLK_DIV cycles
// S_SHIFT | SCK toggling every CLK_DIV cycles, frame shifting
// S_DONE  | CS released, ack issued if cyc still high
// S_GAP   | CS held high CLK_DIV cycles; no request accepted
module spi_sram_multi #(
  parameter int N_CS    = 2,
  parameter int AB      = 16,
  parameter int CLK_DIV = 1,
  parameter int CSB     = (N_CS > 1) ? $clog2(N_CS) : 0,
  parameter int AW      = AB - 2 + CSB
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cyc,
  input  logic [AW-1:0]   adr,
  input  logic            we,
  input  logic [31:0]     dat_i,
  input  logic [3:0]      sel,
  output logic [31:0]     dat_o,
  output logic            ack,
  output logic            busy,
  input  logic            spi_miso,
  output logic            spi_clk,
  output logic            spi_mosi,
  output logic [N_CS-1:0] spi_cs_n
);

  localparam int FW  = 8 + AB + 32;
  localparam int BCW = $clog2(FW);
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_DONE, S_GAP} state_t;

  state_t          state_q;
  logic [FW-1:0]   frame_q;
  logic [31:0]     rx_q;
  logic [BCW-1:0]  bits_q;
  logic [DW-1:0]   div_q;
  logic            we_q, chip_ok_q;
  logic            sclk_q, mosi_q, ack_q, busy_q;
  logic [N_CS-1:0] cs_q;
  logic [31:0]     dat_q;

  logic [1:0]      first_c, last_c, span_c;
  logic [2:0]      chip_c;
  logic            chip_ok_c;
  logic [N_CS-1:0] cs_sel_c;
  logic [AB-1:0]   baddr_c;
  logic [31:0]     shifted_c, data_c;
  logic [FW-1:0]   frame_c;
  logic [BCW-1:0]  nbits_c;

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // Chip index comes from the top address bits; a single chip has none.
  generate
    if (CSB > 0) begin : g_chip
      assign chip_c = 3'(adr[AW-1:AB-2]);
    end else begin : g_one
      assign chip_c = 3'd0;
    end
  endgenerate

  // Decode the request: byte span, chip select, and the outgoing frame (MSB first).
  always_comb begin
    first_c = 2'd0;
    last_c  = 2'd0;
    for (int i = 3; i >= 0; i--) if (sel[i]) first_c = 2'(i);
    for (int i = 0; i < 4; i++)  if (sel[i]) last_c = 2'(i);
    span_c    = last_c - first_c;
    chip_ok_c = chip_c < 3'(N_CS);
    cs_sel_c  = '1;
    for (int i = 0; i < N_CS; i++) if (chip_c == 3'(i)) cs_sel_c[i] = 1'b0;
    baddr_c   = {adr[AB-3:0], (we ? first_c : 2'b00)};
    // Byte 'first' moves to the top so data leaves in ascending byte order.
    shifted_c = dat_i >> {first_c, 3'b000};
    data_c    = we ? bswap(shifted_c) : 32'h0;
    frame_c   = {(we ? 8'h02 : 8'h03), baddr_c, data_c};
    nbits_c   = we ? (BCW'(8 + AB + 7) + BCW'({span_c, 3'b000})) : BCW'(FW - 1);
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      rx_q      <= '0;
      bits_q    <= '0;
      div_q     <= '0;
      we_q      <= 1'b0;
      chip_ok_q <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      cs_q      <= '1;
      dat_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cyc) begin
            busy_q    <= 1'b1;
            we_q      <= we;
            chip_ok_q <= chip_ok_c;
            frame_q   <= {frame_c[FW-2:0], 1'b0};
            bits_q    <= nbits_c;
            div_q     <= DIV_LOAD;
            if (we && (sel == 4'b0000)) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_SETUP;
              cs_q    <= cs_sel_c;
              mosi_q  <= frame_c[FW-1];
            end
          end
        end
        S_SETUP: begin
          if (div_q == '0) begin
            div_q   <= DIV_LOAD;
            state_q <= S_SHIFT;
          end else begin
            div_q <= div_q - 1'b1;
          end
        end
        S_SHIFT: begin
          if (div_q != '0) begin
            div_q <= div_q - 1'b1;
          end else begin
            div_q <= DIV_LOAD;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[30:0], spi_miso};
            end else begin
              sclk_q <= 1'b0;
              if (bits_q == '0) begin
                state_q <= S_DONE;
                cs_q    <= '1;
                mosi_q  <= 1'b0;
              end else begin
                bits_q  <= bits_q - 1'b1;
                mosi_q  <= frame_q[FW-1];
                frame_q <= {frame_q[FW-2:0], 1'b0};
              end
            end
          end
        end
        S_DONE: begin
          ack_q   <= cyc;
          if (cyc && !we_q) dat_q <= chip_ok_q ? bswap(rx_q) : 32'h0;
          div_q   <= DIV_LOAD;
          state_q <= S_GAP;
        end
        S_GAP: begin
          busy_q <= 1'b0;
          if (div_q == '0) state_q <= S_IDLE;
          else             div_q <= div_q - 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dat_o    = dat_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_q;

endmodule

// File: tb/tb_spi_sram_multi.sv
// Bench for spi_sram_multi: a behavioural SPI SRAM on the pins, a byte-array
// reference memory, and one task per scenario.
module tb_spi_sram_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic [14:0] adr = '0;
  logic        we = 1'b0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_o;
  logic        ack, busy;
  logic        spi_miso = 1'b0;
  logic        spi_clk, spi_mosi;
  logic [1:0]  spi_cs_n;

  logic        cyc3 = 1'b0;
  logic [14:0] adr3 = '0;
  logic [31:0] dat_o3;
  logic        ack3, busy3, sclk3, mosi3;
  logic [1:0]  cs3;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_sram_multi #(.N_CS(2), .AB(16), .CLK_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .cyc(cyc), .adr(adr), .we(we), .dat_i(dat_i),
    .sel(sel), .dat_o(dat_o), .ack(ack), .busy(busy), .spi_miso(spi_miso),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n));

  spi_sram_multi #(.N_CS(2), .AB(16), .CLK_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cyc(cyc3), .adr(adr3), .we(1'b0), .dat_i(32'h0),
    .sel(4'hF), .dat_o(dat_o3), .ack(ack3), .busy(busy3), .spi_miso(1'b1),
    .spi_clk(sclk3), .spi_mosi(mosi3), .spi_cs_n(cs3));

  // ---------------- behavioural SPI SRAM pair ----------------
  logic [7:0] sram    [0:1][0:65535];
  logic [7:0] ref_mem [0:1][0:65535];
  logic       frame_bits[$];
  logic       last_frame[$];
  logic [1:0] prev_cs = 2'b11;
  logic [1:0] last_cs = 2'b11;
  int cur_chip = -1, last_chip = -1;
  int cs_fall_cnt = 0, frame_done = 0, sck_rises = 0, ack_hi = 0;
  logic [7:0] cmd = 8'h00;
  int baddr = 0;

  always @(spi_cs_n) begin
    if ((spi_cs_n inside {2'b10, 2'b01, 2'b00}) && prev_cs === 2'b11) begin
      cs_fall_cnt++;
      last_cs  = spi_cs_n;
      cur_chip = (spi_cs_n == 2'b10) ? 0 : (spi_cs_n == 2'b01) ? 1 : -1;
      cmd      = 8'h00;
      frame_bits.delete();
    end else if (spi_cs_n === 2'b11 && (prev_cs inside {2'b10, 2'b01, 2'b00})) begin
      last_frame = frame_bits;
      last_chip  = cur_chip;
      frame_done++;
    end
    prev_cs = spi_cs_n;
  end

  always @(posedge spi_clk) begin
    int nb;
    logic [7:0] b;
    sck_rises++;
    if (spi_cs_n !== 2'b11 && cur_chip >= 0) begin
      frame_bits.push_back(spi_mosi);
      nb = frame_bits.size();
      if (nb == 24) begin
        cmd = 8'h00;
        for (int i = 0; i < 8; i++) cmd = {cmd[6:0], frame_bits[i]};
        baddr = 0;
        for (int i = 8; i < 24; i++) baddr = (baddr << 1) | int'(frame_bits[i]);
      end
      if (cmd == 8'h02 && nb > 24 && ((nb - 24) % 8) == 0) begin
        b = 8'h00;
        for (int i = nb - 8; i < nb; i++) b = {b[6:0], frame_bits[i]};
        sram[cur_chip][(baddr + (nb - 24) / 8 - 1) & 32'hFFFF] = b;
      end
    end
  end

  always @(negedge spi_clk) begin
    int nb, j;
    logic [7:0] b;
    nb = frame_bits.size();
    if (cmd == 8'h03 && cur_chip >= 0 && nb >= 24 && nb < 56) begin
      j = nb - 24;
      b = sram[cur_chip][(baddr + j / 8) & 32'hFFFF];
      spi_miso = b[7 - (j % 8)];
    end
  end

  always @(negedge clk) if (ack === 1'b1) ack_hi++;

  // ---------------- reference model and helpers ----------------
  function automatic void ref_write(input int c, input int wa, input logic [31:0] d, input logic [3:0] s);
    int f, l;
    f = -1; l = -1;
    for (int b = 0; b < 4; b++) if (s[b]) begin if (f < 0) f = b; l = b; end
    if (f < 0) return;
    for (int b = f; b <= l; b++) ref_mem[c][(wa * 4 + b) & 32'hFFFF] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] ref_read(input int c, input int wa);
    return {ref_mem[c][wa*4+3], ref_mem[c][wa*4+2], ref_mem[c][wa*4+1], ref_mem[c][wa*4]};
  endfunction

  function automatic int frame_len(input logic w, input logic [3:0] s);
    int f, l;
    if (!w) return 8 + 16 + 32;
    f = -1; l = -1;
    for (int b = 0; b < 4; b++) if (s[b]) begin if (f < 0) f = b; l = b; end
    return 8 + 16 + 8 * (l - f + 1);
  endfunction

  function automatic int exp_lat(input logic w, input logic [3:0] s, input int d);
    if (w && s == 4'b0000) return 2;
    return 2 + d * (1 + 2 * frame_len(w, s));
  endfunction

  function automatic logic [7:0] fbyte(input int k);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++)
      if (8 * k + i < last_frame.size()) b = {b[6:0], last_frame[8*k+i]};
    return b;
  endfunction

  task automatic do_xfer(input logic w, input logic [14:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int lat, output logic busy_at_ack);
    logic got;
    @(negedge clk);
    cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    lat = 0; busy_at_ack = 1'b0; got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (ack === 1'b1) begin got = 1'b1; busy_at_ack = busy; end
    end
    if (!got) lat = -1;
    cyc = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (spi_cs_n !== 2'b11) begin n_fail++; $display("FAIL reset_cs: got %b expected 11", spi_cs_n); end
    n_checks++; if (spi_clk !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b expected 0", spi_clk); end
    n_checks++; if (spi_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", spi_mosi); end
    n_checks++; if (ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ack_busy: got %b%b expected 00", ack, busy); end
    n_checks++; if (dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h expected 00000000", dat_o); end
    n_checks++; if (cs3 !== 2'b11 || sclk3 !== 1'b0) begin n_fail++; $display("FAIL reset_dut3: got cs %b sck %b expected 11 0", cs3, sclk3); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (spi_cs_n !== 2'b11 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got cs %b busy %b expected 11 0", spi_cs_n, busy); end
  endtask

  task automatic test_word_read();
    int lat, a0; logic bz;
    a0 = ack_hi;
    do_xfer(1'b0, 15'h0004, 32'h0, 4'hF, lat, bz);
    n_checks++; if (lat != 115) begin n_fail++; $display("FAIL read_latency: got %0d expected 115", lat); end
    n_checks++; if (dat_o !== 32'h44332211) begin n_fail++; $display("FAIL read_data: got %h expected 44332211", dat_o); end
    n_checks++; if (last_cs !== 2'b10) begin n_fail++; $display("FAIL read_cs: got %b expected 10", last_cs); end
    n_checks++; if ({fbyte(0), fbyte(1), fbyte(2)} !== 24'h030010) begin n_fail++; $display("FAIL read_header: got %h expected 030010", {fbyte(0), fbyte(1), fbyte(2)}); end
    n_checks++; if (last_frame.size() != 56) begin n_fail++; $display("FAIL read_bits: got %0d expected 56", last_frame.size()); end
    n_checks++; if (bz !== 1'b1) begin n_fail++; $display("FAIL busy_in_ack: got %b expected 1", bz); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after: got %b expected 0", busy); end
    n_checks++; if (ack_hi - a0 != 1) begin n_fail++; $display("FAIL ack_width: got %0d expected 1", ack_hi - a0); end
  endtask

  task automatic test_byte_write();
    int lat; logic bz;
    ref_write(0, 1, 32'hAABBCCDD, 4'b0100);
    do_xfer(1'b1, 15'h0001, 32'hAABBCCDD, 4'b0100, lat, bz);
    n_checks++; if (lat != 67) begin n_fail++; $display("FAIL bwr_latency: got %0d expected 67", lat); end
    n_checks++; if (last_frame.size() != 32) begin n_fail++; $display("FAIL bwr_bits: got %0d expected 32", last_frame.size()); end
    n_checks++; if ({fbyte(0), fbyte(1), fbyte(2), fbyte(3)} !== 32'h020006BB) begin n_fail++; $display("FAIL bwr_frame: got %h expected 020006BB", {fbyte(0), fbyte(1), fbyte(2), fbyte(3)}); end
    n_checks++; if (sram[0][6] !== 8'hBB) begin n_fail++; $display("FAIL bwr_mem: got %h expected BB", sram[0][6]); end
    n_checks++; if (sram[0][5] !== ref_mem[0][5] || sram[0][7] !== ref_mem[0][7]) begin n_fail++; $display("FAIL bwr_neighbours: got %h %h expected %h %h", sram[0][5], sram[0][7], ref_mem[0][5], ref_mem[0][7]); end
    n_checks++; if (dat_o !== 32'h44332211) begin n_fail++; $display("FAIL dat_hold: got %h expected 44332211", dat_o); end
  endtask

  task automatic test_halfword();
    int lat; logic bz;
    ref_write(1, 0, 32'hAABBCCDD, 4'b1100);
    do_xfer(1'b1, 15'h4000, 32'hAABBCCDD, 4'b1100, lat, bz);
    n_checks++; if (last_cs !== 2'b01) begin n_fail++; $display("FAIL hw_cs: got %b expected 01", last_cs); end
    n_checks++; if ({fbyte(0), fbyte(1), fbyte(2), fbyte(3), fbyte(4)} !== 40'h020002BBAA) begin n_fail++; $display("FAIL hw_frame: got %h expected 020002BBAA", {fbyte(0), fbyte(1), fbyte(2), fbyte(3), fbyte(4)}); end
    n_checks++; if (lat != 83) begin n_fail++; $display("FAIL hw_latency: got %0d expected 83", lat); end
    do_xfer(1'b0, 15'h4000, 32'h0, 4'hF, lat, bz);
    n_checks++; if (dat_o[31:16] !== 16'hAABB) begin n_fail++; $display("FAIL hw_readback: got %h expected AABB", dat_o[31:16]); end
    n_checks++; if (dat_o !== ref_read(1, 0)) begin n_fail++; $display("FAIL hw_readback_full: got %h expected %h", dat_o, ref_read(1, 0)); end
  endtask

  task automatic test_sel_zero();
    int lat, c0, r0; logic bz;
    c0 = cs_fall_cnt; r0 = sck_rises;
    do_xfer(1'b1, 15'h0003, 32'h12345678, 4'b0000, lat, bz);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL sel0_latency: got %0d expected 2", lat); end
    n_checks++; if (cs_fall_cnt != c0 || sck_rises != r0) begin n_fail++; $display("FAIL sel0_quiet: got cs %0d sck %0d expected 0 0", cs_fall_cnt - c0, sck_rises - r0); end
  endtask

  task automatic test_random();
    logic [3:0] sels [12];
    int lat, c, wa, fd0, bad;
    logic w, bz;
    logic [3:0] s;
    logic [31:0] d;
    sels = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'h7, 4'hE, 4'hF, 4'h5, 4'h0};
    for (int t = 0; t < 24; t++) begin
      c  = $urandom_range(0, 1);
      wa = $urandom_range(0, 63);
      w  = 1'($urandom_range(0, 1));
      s  = sels[$urandom_range(0, 11)];
      d  = $urandom;
      fd0 = frame_done;
      if (w) ref_write(c, wa, d, s);
      do_xfer(w, {c[0], 14'(wa)}, d, s, lat, bz);
      n_checks++; if (lat != exp_lat(w, s, 1)) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", t, lat, exp_lat(w, s, 1)); end
      if (!(w && s == 4'b0000)) begin
        n_checks++; if (frame_done != fd0 + 1 || last_chip != c || last_frame.size() != frame_len(w, s)) begin
          n_fail++; $display("FAIL rnd_frame[%0d]: got chip %0d bits %0d expected chip %0d bits %0d", t, last_chip, last_frame.size(), c, frame_len(w, s));
        end
      end
      if (!w) begin
        n_checks++; if (dat_o !== ref_read(c, wa)) begin n_fail++; $display("FAIL rnd_read[%0d]: got %h expected %h", t, dat_o, ref_read(c, wa)); end
      end
    end
    bad = 0;
    for (int ch = 0; ch < 2; ch++)
      for (int a = 0; a < 256; a++) if (sram[ch][a] !== ref_mem[ch][a]) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mem_sweep: got %0d differing bytes expected 0", bad); end
  endtask

  task automatic test_cyc_drop();
    int a0, fd0;
    a0 = ack_hi; fd0 = frame_done;
    @(negedge clk);
    cyc = 1'b1; we = 1'b0; adr = 15'h4001; sel = 4'hF;
    repeat (20) @(negedge clk);
    cyc = 1'b0;
    repeat (150) @(negedge clk);
    n_checks++; if (ack_hi != a0) begin n_fail++; $display("FAIL drop_no_ack: got %0d acks expected 0", ack_hi - a0); end
    n_checks++; if (frame_done != fd0 + 1 || last_frame.size() != 56) begin n_fail++; $display("FAIL drop_frame: got %0d frames %0d bits expected 1 frame 56 bits", frame_done - fd0, last_frame.size()); end
  endtask

  task automatic test_reset_mid();
    int a0, lat; logic bz;
    a0 = ack_hi;
    @(negedge clk);
    cyc = 1'b1; we = 1'b0; adr = 15'h0004; sel = 4'hF;
    repeat (40) @(negedge clk);
    n_checks++; if (spi_cs_n !== 2'b10) begin n_fail++; $display("FAIL mid_active: got %b expected 10", spi_cs_n); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (spi_cs_n !== 2'b11 || spi_clk !== 1'b0) begin n_fail++; $display("FAIL mid_reset_pins: got cs %b sck %b expected 11 0", spi_cs_n, spi_clk); end
    cyc = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    n_checks++; if (ack_hi != a0 || dat_o !== 32'h0) begin n_fail++; $display("FAIL mid_no_ack: got %0d acks dat %h expected 0 00000000", ack_hi - a0, dat_o); end
    do_xfer(1'b0, 15'h0004, 32'h0, 4'hF, lat, bz);
    n_checks++; if (lat != 115 || dat_o !== ref_read(0, 4)) begin n_fail++; $display("FAIL mid_recover: got lat %0d dat %h expected 115 %h", lat, dat_o, ref_read(0, 4)); end
  endtask

  task automatic test_clkdiv3();
    int lat, hi_bad, lo_bad, rises, run, gap;
    logic prev, got, bz, ack_next;
    logic [7:0] cmd3;
    @(negedge clk);
    cyc3 = 1'b1; adr3 = 15'h0004;
    lat = 0; hi_bad = 0; lo_bad = 0; rises = 0; run = 0; prev = 1'b0; got = 1'b0; bz = 1'b0; cmd3 = 8'h00;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (sclk3 === prev) run++;
      else begin
        if (prev && run != 3) hi_bad++;
        if (!prev && rises > 0 && run != 3) lo_bad++;
        if (sclk3) begin
          rises++;
          if (rises <= 8) cmd3 = {cmd3[6:0], mosi3};
        end
        run = 1;
      end
      prev = sclk3;
      if (ack3 === 1'b1) begin got = 1'b1; bz = busy3; end
    end
    n_checks++; if (lat != 341) begin n_fail++; $display("FAIL div3_latency: got %0d expected 341", lat); end
    n_checks++; if (hi_bad != 0 || lo_bad != 0) begin n_fail++; $display("FAIL div3_sck_width: got %0d high %0d low bad runs expected 0 0", hi_bad, lo_bad); end
    n_checks++; if (rises != 56 || cmd3 !== 8'h03) begin n_fail++; $display("FAIL div3_frame: got %0d rises cmd %h expected 56 03", rises, cmd3); end
    n_checks++; if (dat_o3 !== 32'hFFFFFFFF || bz !== 1'b1) begin n_fail++; $display("FAIL div3_data: got %h busy %b expected FFFFFFFF 1", dat_o3, bz); end
    gap = 0; ack_next = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (cs3 !== 2'b11) break;
      gap++;
      @(negedge clk);
      if (k == 0) ack_next = ack3;
    end
    n_checks++; if (ack_next !== 1'b0) begin n_fail++; $display("FAIL div3_ack_pulse: got %b expected 0", ack_next); end
    n_checks++; if (gap < 3) begin n_fail++; $display("FAIL div3_gap: got %0d expected >=3", gap); end
    got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      if (ack3 === 1'b1) got = 1'b1;
    end
    cyc3 = 1'b0;
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL div3_second: got %b expected 1", got); end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 65536; a++) begin
        sram[c][a] = 8'h00;
        ref_mem[c][a] = 8'h00;
      end
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 256; a++) begin
        sram[c][a] = 8'($urandom);
        ref_mem[c][a] = sram[c][a];
      end
    sram[0][16] = 8'h11; sram[0][17] = 8'h22; sram[0][18] = 8'h33; sram[0][19] = 8'h44;
    ref_mem[0][16] = 8'h11; ref_mem[0][17] = 8'h22; ref_mem[0][18] = 8'h33; ref_mem[0][19] = 8'h44;
    test_reset();
    test_word_read();
    test_byte_write();
    test_halfword();
    test_sel_zero();
    test_random();
    test_cyc_drop();
    test_reset_mid();
    test_clkdiv3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
